// File: rtl/dw_rbsh_inst.sv
// dw_rbsh_inst -- registered rotate-right barrel shifter (FP add/sub datapath).
//
// Rotates Data_i right by Shift_Value_i, read as unsigned (inst_SH_TC = 0) or
// two's complement (inst_SH_TC = 1; negative amounts rotate left). Amounts
// wrap modulo SWR, including non-power-of-two SWR. The result is captured
// into Data_o on a rising clk edge when load_i is high.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous reset, active low (clears Data_o)
//   load_i         output register capture enable
//   Data_i         [SWR-1:0] word to rotate
//   Shift_Value_i  [EWR-1:0] rotate amount
//   inst_SH_TC     amount encoding: 0 unsigned, 1 two's complement
//   Data_o         [SWR-1:0] registered rotated word

// One log stage: conditionally rotate right by the constant D.
module dw_rbsh_stage #(
    parameter int SWR = 8,
    parameter int D   = 1
) (
    input  logic           sel,
    input  logic [SWR-1:0] x,
    output logic [SWR-1:0] y
);
    logic [2*SWR-1:0] dbl;
    logic [SWR-1:0]   rr;

    // Bit j of a right rotation by D is x[(j+D) mod SWR] = {x,x}[j+D].
    assign dbl = {x, x};
    assign rr  = dbl[D +: SWR];
    assign y   = sel ? rr : x;
endmodule

module dw_rbsh_inst #(
    parameter int SWR = 8,
    parameter int EWR = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic [SWR-1:0] Data_i,
    input  logic [EWR-1:0] Shift_Value_i,
    input  logic           inst_SH_TC,
    output logic [SWR-1:0] Data_o
);
    localparam int KW = (SWR > 1) ? $clog2(SWR) : 1;
    localparam int MW = EWR + KW + 1;

    // Restoring reduction a mod SWR: compare/subtract against SWR<<i, MSB
    // first. a < 2^(EWR+1) <= SWR<<EWR, so starting at i = EWR suffices.
    function automatic logic [KW-1:0] mod_swr(input logic [EWR:0] a);
        logic [MW-1:0] r;
        logic [MW-1:0] m;
        r = MW'(a);
        for (int i = EWR; i >= 0; i--) begin
            m = MW'(SWR) << i;
            if (r >= m) r = r - m;
        end
        return r[KW-1:0];
    endfunction

    logic           neg;
    logic [EWR:0]   mag;
    logic [KW-1:0]  m_red;
    logic [KW:0]    k_wide;
    logic [KW-1:0]  k;

    // Magnitude is EWR+1 bits so that -2^(EWR-1) negates without overflow.
    assign neg    = inst_SH_TC & Shift_Value_i[EWR-1];
    assign mag    = neg ? (~{1'b1, Shift_Value_i} + 1'b1) : {1'b0, Shift_Value_i};
    assign m_red  = mod_swr(mag);
    // Left by m equals right by SWR-m; m = 0 must stay 0, not become SWR.
    assign k_wide = (KW+1)'(SWR) - {1'b0, m_red};
    assign k      = (neg && (m_red != '0)) ? k_wide[KW-1:0] : m_red;

    // stg[i] feeds stage i; stage i rotates by 2^i when k[i] is set.
    logic [KW:0][SWR-1:0] stg;
    assign stg[0] = Data_i;

    for (genvar i = 0; i < KW; i++) begin : g_stage
        dw_rbsh_stage #(
            .SWR (SWR),
            .D   ((1 << i) % SWR)
        ) u_stage (
            .sel (k[i]),
            .x   (stg[i]),
            .y   (stg[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        Data_o <= '0;
        else if (load_i) Data_o <= stg[KW];
    end
endmodule

// File: tb/tb_dw_rbsh_inst.sv
module tb_dw_rbsh_inst;
    logic       clk;
    logic       rst;
    logic       load_i;
    logic [7:0] Data_i;
    logic [2:0] Shift_Value_i;
    logic       inst_SH_TC;
    logic [7:0] Data_o;

    int n_cmp;
    int n_err;

    dw_rbsh_inst #(.SWR(8), .EWR(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .load_i        (load_i),
        .Data_i        (Data_i),
        .Shift_Value_i (Shift_Value_i),
        .inst_SH_TC    (inst_SH_TC),
        .Data_o        (Data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: signed/unsigned amount as an integer, reduced with %, then
    // each output bit picked from its rotated source position.
    function automatic logic [7:0] ref_rot(input logic [7:0] d, input logic [2:0] sv,
                                           input logic tc);
        int s, k;
        logic [7:0] r;
        s = int'(sv);
        if (tc && sv[2]) s = s - 8;
        k = ((s % 8) + 8) % 8;
        for (int j = 0; j < 8; j++) r[j] = d[(j + k) % 8];
        return r;
    endfunction

    // Drive on the falling edge, sample 1 time unit after the next rising edge.
    task automatic step(input logic [7:0] d, input logic [2:0] sv, input logic tc,
                        input logic ld);
        @(negedge clk);
        Data_i = d; Shift_Value_i = sv; inst_SH_TC = tc; load_i = ld;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0] sv;
        logic       tc;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[9];
    logic [7:0] model;
    logic [7:0] d;
    logic [2:0] sv;
    logic       tc, ld;

    initial begin
        n_cmp = 0; n_err = 0;
        vecs[0] = '{3'd0, 1'b0, 8'h96};
        vecs[1] = '{3'd1, 1'b0, 8'h4B};
        vecs[2] = '{3'd3, 1'b0, 8'hD2};
        vecs[3] = '{3'd4, 1'b0, 8'h69};
        vecs[4] = '{3'd7, 1'b0, 8'h2D};
        vecs[5] = '{3'b001, 1'b1, 8'h4B};
        vecs[6] = '{3'b101, 1'b1, 8'hB4};
        vecs[7] = '{3'b111, 1'b1, 8'h2D};
        vecs[8] = '{3'b100, 1'b1, 8'h69};

        // Reset held with clocks running and nonzero inputs.
        rst = 1'b0; load_i = 1'b1; Data_i = 8'h96; Shift_Value_i = 3'd1; inst_SH_TC = 1'b0;
        #1;
        chk("reset_immediate", Data_o, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_held", Data_o, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("first_load", Data_o, 8'h4B);

        // Directed unsigned and signed vectors.
        foreach (vecs[i]) begin
            step(8'h96, vecs[i].sv, vecs[i].tc, 1'b1);
            chk($sformatf("dir_sv%0d_tc%0d", vecs[i].sv, vecs[i].tc), Data_o, vecs[i].exp);
        end

        // Hold with load_i low while inputs change.
        step(8'h96, 3'd3, 1'b0, 1'b1);
        chk("hold_load", Data_o, 8'hD2);
        for (int i = 0; i < 5; i++) begin
            step(8'($urandom), 3'($urandom), 1'($urandom), 1'b0);
            chk($sformatf("hold_%0d", i), Data_o, 8'hD2);
        end

        // Asynchronous reset between edges.
        step(8'h96, 3'd3, 1'b0, 1'b1);
        chk("pre_async", Data_o, 8'hD2);
        #2 rst = 1'b0;
        #1;
        chk("async_clear", Data_o, 8'h00);
        @(posedge clk);
        #1;
        chk("async_held", Data_o, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        step(8'h96, 3'b101, 1'b1, 1'b1);
        chk("reload", Data_o, 8'hB4);

        // Every amount under both encodings with random data.
        for (int rep = 0; rep < 8; rep++) begin
            for (int s = 0; s < 8; s++) begin
                for (int t = 0; t < 2; t++) begin
                    d = 8'($urandom);
                    step(d, 3'(s), 1'(t), 1'b1);
                    chk($sformatf("sweep_sv%0d_tc%0d", s, t), Data_o, ref_rot(d, 3'(s), 1'(t)));
                    chk("popcount", 8'($countones(Data_o)), 8'($countones(d)));
                end
            end
        end

        // Random stream with random load enable; model tracks held value.
        model = Data_o;
        for (int i = 0; i < 200; i++) begin
            d  = 8'($urandom);
            sv = 3'($urandom);
            tc = 1'($urandom);
            ld = ($urandom_range(0, 3) != 0);
            if (ld) model = ref_rot(d, sv, tc);
            step(d, sv, tc, ld);
            chk("rand_stream", Data_o, model);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
